// File: rtl/gpio.sv
// Memory-mapped GPIO port: direction/output registers, two-flop input
// synchronizer, and two edge-triggered interrupt channels with W1C pending bits.
//
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   en, we          bus strobe and write select (read when en & ~we)
//   addr[3:0]       byte address in the port window; addr[1:0] ignored
//   wr_data[31:0]   write data, byte lanes gated by wr_strobe[3:0]
//   rd_data[31:0]   registered read data, held between reads
//   gpio_i          asynchronous pad inputs
//   gpio_o, gpio_oe pad output values and output enables (1 = drive)
//   int0, int1      level interrupt requests (pending bits of each channel)
module gpio #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             we,
  input  logic [3:0]       addr,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_strobe,
  output logic [31:0]      rd_data,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             int0,
  output logic             int1
);

  localparam int unsigned PIN_MAX = 16;
  localparam int unsigned SEL_W   = 4;

  localparam logic [1:0] REG_DIR    = 2'd0;
  localparam logic [1:0] REG_IN     = 2'd1;
  localparam logic [1:0] REG_OUT    = 2'd2;
  localparam logic [1:0] REG_INTCFG = 2'd3;

  logic [WIDTH-1:0]   dir;
  logic [WIDTH-1:0]   dout;
  logic [WIDTH-1:0]   s1;
  logic [WIDTH-1:0]   s2;
  logic [WIDTH-1:0]   prev;
  logic [SEL_W-1:0]   sel0;
  logic [SEL_W-1:0]   sel1;
  logic [1:0]         mode0;
  logic [1:0]         mode1;
  logic               pend0;
  logic               pend1;

  logic               wr_acc;
  logic               rd_acc;
  logic [1:0]         reg_idx;
  logic [PIN_MAX-1:0] lane_mask;
  logic [PIN_MAX-1:0] s2_ext;
  logic [PIN_MAX-1:0] prev_ext;
  logic               ev0;
  logic               ev1;
  logic               clr0;
  logic               clr1;
  logic [31:0]        rd_mux;
  logic               unused_bits;

  // Edge match for one channel; a select beyond the implemented pins never fires.
  function automatic logic edge_hit(input logic [1:0] mode,
                                    input logic [SEL_W-1:0] sel,
                                    input logic [PIN_MAX-1:0] cur,
                                    input logic [PIN_MAX-1:0] old);
    logic rise;
    logic fall;
    logic hit;
    rise = cur[sel] & ~old[sel];
    fall = ~cur[sel] & old[sel];
    hit  = 1'b0;
    if ({1'b0, sel} < 5'(WIDTH)) begin
      case (mode)
        2'b01:   hit = rise;
        2'b10:   hit = fall;
        2'b11:   hit = rise | fall;
        default: hit = 1'b0;
      endcase
    end
    return hit;
  endfunction

  assign wr_acc    = en & we;
  assign rd_acc    = en & ~we;
  assign reg_idx   = addr[3:2];
  assign lane_mask = {{8{wr_strobe[1]}}, {8{wr_strobe[0]}}};
  assign s2_ext    = PIN_MAX'(s2);
  assign prev_ext  = PIN_MAX'(prev);

  assign ev0 = edge_hit(mode0, sel0, s2_ext, prev_ext);
  assign ev1 = edge_hit(mode1, sel1, s2_ext, prev_ext);

  // W1C qualified by the byte lane holding each pending bit.
  assign clr0 = wr_acc && (reg_idx == REG_INTCFG) && wr_strobe[0] && wr_data[6];
  assign clr1 = wr_acc && (reg_idx == REG_INTCFG) && wr_strobe[1] && wr_data[14];

  // Bits outside the implemented register fields are intentionally dropped.
  assign unused_bits = ^{addr[1:0], wr_data, wr_strobe[3:2], lane_mask};

  // Read data selection.
  always_comb begin
    rd_mux = 32'd0;
    case (reg_idx)
      REG_DIR:    rd_mux = 32'(dir);
      REG_IN:     rd_mux = 32'(s2);
      REG_OUT:    rd_mux = 32'(dout);
      REG_INTCFG: rd_mux = {17'd0, pend1, mode1, sel1, 1'b0, pend0, mode0, sel0};
      default:    rd_mux = 32'd0;
    endcase
  end

  // Synchronizer and edge-history pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= gpio_i;
      s2   <= s1;
      prev <= s2;
    end
  end

  // Bus-writable registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dir   <= '0;
      dout  <= '0;
      sel0  <= '0;
      sel1  <= '0;
      mode0 <= '0;
      mode1 <= '0;
    end else if (wr_acc) begin
      case (reg_idx)
        REG_DIR: dir <= (dir & ~lane_mask[WIDTH-1:0])
                      | (wr_data[WIDTH-1:0] & lane_mask[WIDTH-1:0]);
        REG_OUT: dout <= (dout & ~lane_mask[WIDTH-1:0])
                       | (wr_data[WIDTH-1:0] & lane_mask[WIDTH-1:0]);
        REG_INTCFG: begin
          if (wr_strobe[0]) begin
            sel0  <= wr_data[3:0];
            mode0 <= wr_data[5:4];
          end
          if (wr_strobe[1]) begin
            sel1  <= wr_data[11:8];
            mode1 <= wr_data[13:12];
          end
        end
        default: ;
      endcase
    end
  end

  // Pending bits: an event wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend0 <= 1'b0;
      pend1 <= 1'b0;
    end else begin
      pend0 <= ev0 | (pend0 & ~clr0);
      pend1 <= ev1 | (pend1 & ~clr1);
    end
  end

  // Read data register; holds when no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= 32'd0;
    end else if (rd_acc) begin
      rd_data <= rd_mux;
    end
  end

  assign gpio_oe = dir;
  assign gpio_o  = dout;
  assign int0    = pend0;
  assign int1    = pend1;

endmodule

// File: tb/tb_gpio.sv
// Directed bench for gpio: a 16-pin port plus an 8-pin port sharing the bus.
module tb_gpio;

  logic        clk;
  logic        rst;
  logic        en;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strobe;
  logic [15:0] gpio_i;

  logic [31:0] rd_data;
  logic [15:0] gpio_o;
  logic [15:0] gpio_oe;
  logic        int0;
  logic        int1;

  logic [31:0] rd_data8;
  logic [7:0]  gpio_o8;
  logic [7:0]  gpio_oe8;
  logic        int0_8;
  logic        int1_8;

  int checks;
  int errors;

  gpio #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr),
    .wr_data(wr_data), .wr_strobe(wr_strobe), .rd_data(rd_data),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe),
    .int0(int0), .int1(int1)
  );

  gpio #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr),
    .wr_data(wr_data), .wr_strobe(wr_strobe), .rd_data(rd_data8),
    .gpio_i(gpio_i[7:0]), .gpio_o(gpio_o8), .gpio_oe(gpio_oe8),
    .int0(int0_8), .int1(int1_8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance n edges; inputs and samples land 1 time unit after each edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    en = 1'b1; we = 1'b1; addr = a; wr_data = d; wr_strobe = s;
    step(1);
    en = 1'b0; we = 1'b0; wr_strobe = 4'd0;
  endtask

  task automatic bus_read(input logic [3:0] a);
    en = 1'b1; we = 1'b0; addr = a;
    step(1);
    en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got 0x%08h expected 0x%08h", 0, 1);
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; en = 1'b0; we = 1'b0; addr = 4'd0;
    wr_data = 32'd0; wr_strobe = 4'd0; gpio_i = 16'hFFFF;

    // Reset with all pins high.
    step(3);
    check("rst_oe",   32'(gpio_oe), 32'h0);
    check("rst_o",    32'(gpio_o),  32'h0);
    check("rst_rd",   rd_data,      32'h0);
    check("rst_ints", {30'd0, int1, int0}, 32'h0);
    rst = 1'b0;
    step(10);
    check("idle_ints", {30'd0, int1, int0}, 32'h0);
    bus_read(4'h4);
    check("in_high", rd_data, 32'h0000_FFFF);

    // DIR/OUT writes with partial byte lanes.
    bus_write(4'h0, 32'h0000_00FF, 4'b0011);
    bus_write(4'h8, 32'h0000_A5A5, 4'b0001);
    check("oe_ff", 32'(gpio_oe), 32'h0000_00FF);
    check("o_a5",  32'(gpio_o),  32'h0000_00A5);
    bus_read(4'h8);
    check("rd_out", rd_data, 32'h0000_00A5);
    step(1);
    check("rd_hold", rd_data, 32'h0000_00A5);
    bus_write(4'h4, 32'h0000_1234, 4'b1111);
    check("wr_no_rd", rd_data, 32'h0000_00A5);
    bus_read(4'h4);
    check("in_ro", rd_data, 32'h0000_FFFF);
    bus_read(4'h0);
    check("rd_dir", rd_data, 32'h0000_00FF);

    // Channel 0: pin 3 rising.
    gpio_i = 16'h0000;
    step(3);
    bus_write(4'hC, 32'h0000_0013, 4'b0001);
    bus_read(4'hC);
    check("cfg0", rd_data, 32'h0000_0013);
    gpio_i[3] = 1'b1;
    step(1);                       // edge k: captured into s1
    check("int0_k", 32'(int0), 32'h0);
    bus_read(4'h4);                // edge k+1: loads pre-edge IN
    check("in_k1", rd_data, 32'h0);
    check("int0_k1", 32'(int0), 32'h0);
    bus_read(4'h4);                // edge k+2
    check("in_k2", rd_data, 32'h0000_0008);
    check("int0_k2", 32'(int0), 32'h1);
    bus_write(4'hC, 32'h0000_0040, 4'b0010);
    check("clr_wrong_lane", 32'(int0), 32'h1);
    bus_write(4'hC, 32'h0000_0040, 4'b0001);
    check("clr0", 32'(int0), 32'h0);
    bus_read(4'hC);
    check("cfg0_clr", rd_data, 32'h0);

    // Channel 1: pin 15, both edges.
    bus_write(4'hC, 32'h0000_3F00, 4'b0010);
    gpio_i[15] = 1'b1;
    step(2);
    check("int1_pre", 32'(int1), 32'h0);
    step(1);
    check("int1_rise", 32'(int1), 32'h1);
    bus_write(4'hC, 32'h0000_7F00, 4'b0010);
    check("clr1", 32'(int1), 32'h0);
    gpio_i[15] = 1'b0;
    step(2);
    check("int1_fall_pre", 32'(int1), 32'h0);
    bus_write(4'hC, 32'h0000_7F00, 4'b0010);  // clear on the falling-event edge
    check("set_wins", 32'(int1), 32'h1);
    bus_write(4'hC, 32'h0000_3E00, 4'b0010);  // reselect keeps pending
    check("sel_keeps_pend", 32'(int1), 32'h1);
    bus_read(4'hC);
    check("cfg1", rd_data, 32'h0000_7E00);
    bus_write(4'hC, 32'h0000_7F00, 4'b0010);
    check("clr1_again", 32'(int1), 32'h0);

    // 8-pin port: out-of-range select and masked upper bits.
    bus_write(4'hC, 32'h0000_001C, 4'b0001);
    gpio_i = 16'h0000;
    step(4);
    gpio_i = 16'hFFFF;
    step(4);
    gpio_i = 16'h0000;
    step(4);
    gpio_i = 16'hFFFF;
    step(4);
    check("w8_no_int", 32'(int0_8), 32'h0);
    check("w16_pin12_int", 32'(int0), 32'h1);
    bus_write(4'h0, 32'h0000_FFFF, 4'b0011);
    check("w8_oe", 32'(gpio_oe8), 32'h0000_00FF);
    check("w16_oe", 32'(gpio_oe), 32'h0000_FFFF);
    bus_read(4'h0);
    check("w8_dir_rd", rd_data8, 32'h0000_00FF);
    bus_read(4'h4);
    check("w8_in_rd", rd_data8, 32'h0000_00FF);

    // Mid-operation reset clears pending and direction.
    rst = 1'b1;
    step(1);
    check("mrst_int0", 32'(int0), 32'h0);
    check("mrst_int1", 32'(int1), 32'h0);
    check("mrst_oe", 32'(gpio_oe), 32'h0);
    check("mrst_rd", rd_data, 32'h0);
    rst = 1'b0;
    step(5);
    check("post_rst_int0", 32'(int0), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
